// File: rtl/inst_fetch.sv
// Byte-serial instruction fetch: IDLE->REQ/WAIT x4->DONE, 9 cycles with a 1-cycle memory.
// Holds PC_reg via stallreq_o while busy; DONE is held while IF/ID (stall_i[1]) is stalled.
module inst_fetch #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    output logic        stallreq_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [7:0]  mem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MAX_WAIT - 1);

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [1:0]     byte_cnt_q, byte_cnt_d;
    logic [31:0]    inst_buf_q, inst_buf_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           err_q, err_d;
    logic           timeout;
    logic           unused_stall;

    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    // The counter holds the number of cycles already spent waiting; MAX_WAIT=0 disables it.
    assign timeout = (MAX_WAIT != 0) && (wait_cnt_q == WAIT_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= 32'd0;
            byte_cnt_q <= 2'd0;
            inst_buf_q <= 32'd0;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            byte_cnt_q <= byte_cnt_d;
            inst_buf_q <= inst_buf_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        byte_cnt_d = byte_cnt_q;
        inst_buf_d = inst_buf_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!flush_i) begin
                    fetch_pc_d = pc_i;
                    byte_cnt_d = 2'd0;
                    state_d    = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    wait_cnt_d = '0;
                    state_d    = flush_i ? S_DRAIN : S_WAIT;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (mem_rvalid_i) begin
                    if (flush_i) begin
                        state_d = S_IDLE;
                    end else begin
                        inst_buf_d[8*byte_cnt_q +: 8] = mem_rdata_i;
                        if (byte_cnt_q == 2'd3) begin
                            state_d = S_DONE;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 2'd1;
                            state_d    = S_REQ;
                        end
                    end
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // One granted byte is still owed by the controller; swallow it before refetching.
                wait_cnt_d = wait_cnt_q + 1'b1;
                if (mem_rvalid_i) begin
                    state_d = S_IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (flush_i || !stall_i[1]) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = (state_q == S_REQ) ? (fetch_pc_q + {30'd0, byte_cnt_q}) : 32'd0;
    assign inst_valid_o = (state_q == S_DONE);
    assign inst_o       = (state_q == S_DONE) ? inst_buf_q : NOP_INST;
    assign inst_pc_o    = (state_q == S_DONE) ? fetch_pc_q : 32'd0;
    assign err_o        = err_q;
    assign stallreq_o   = (state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_DRAIN) ||
                          ((state_q == S_DONE) && stall_i[1]);

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: cycle table for a clean fetch plus hand sequences for corner cases.
module tb_inst_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic [31:0] pc_i;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        stallreq_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        err_o;

    inst_fetch #(.NOP_INST(NOP), .MAX_WAIT(8)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .stall_i(stall_i), .flush_i(flush_i),
        .stallreq_o(stallreq_o), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .inst_o(inst_o), .inst_pc_o(inst_pc_o), .inst_valid_o(inst_valid_o), .err_o(err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        sreq;
        logic        vld;
        logic [31:0] inst;
        logic [31:0] ipc;
        logic        err;
    } out_t;

    typedef struct {
        logic flush;
        out_t exp;
    } vec_t;

    int n_chk = 0;
    int n_pass = 0;

    // Memory model configuration (written by the test) and state (written by the model).
    logic [7:0]  mem [logic [31:0]];
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    int          hold_n = 0;
    logic [31:0] slow_addr = 32'hFFFF_FFFF;
    int          slow_lat = 1;
    bit          no_resp = 1'b0;
    bit          inject = 1'b0;
    bit          pend;
    logic [31:0] pend_addr;
    int          pend_lat;
    int          hold_used;
    int          gnt_cnt;

    function automatic logic [7:0] rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 8'h00;
    endfunction

    always @(negedge clk) begin
        mem_gnt_i    = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 8'h00;
        if (!rst) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                if (pend_lat == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = rd(pend_addr);
                    pend         = 1'b0;
                end else begin
                    pend_lat--;
                end
            end
            if (inject) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 8'hFF;
            end
            if (mem_req_o && !pend) begin
                if (mem_addr_o == hold_addr && hold_used < hold_n) begin
                    hold_used++;
                end else begin
                    mem_gnt_i = 1'b1;
                    gnt_cnt++;
                    if (!no_resp) begin
                        pend      = 1'b1;
                        pend_addr = mem_addr_o;
                        pend_lat  = (mem_addr_o == slow_addr) ? slow_lat - 1 : 0;
                    end
                end
            end
        end
    end

    function automatic out_t cur();
        out_t o;
        o.req = mem_req_o; o.addr = mem_addr_o; o.sreq = stallreq_o; o.vld = inst_valid_o;
        o.inst = inst_o; o.ipc = inst_pc_o; o.err = err_o;
        return o;
    endfunction

    function automatic out_t mk(input logic req, input logic [31:0] addr, input logic sreq,
                                input logic vld, input logic [31:0] inst, input logic [31:0] ipc);
        out_t o;
        o.req = req; o.addr = addr; o.sreq = sreq; o.vld = vld; o.inst = inst; o.ipc = ipc; o.err = 1'b0;
        return o;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    task automatic chk_o(input string nm, input out_t exp);
        out_t a;
        a = cur();
        n_chk++;
        if (a === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, a, exp);
    endtask

    // Inputs change mid-cycle (negedge) and outputs are sampled 1 ns later.
    task automatic cyc_in(input logic [31:0] pc, input logic [5:0] st, input logic fl);
        @(negedge clk);
        pc_i = pc; stall_i = st; flush_i = fl;
        #1;
    endtask

    task automatic wait_valid(input string nm, input logic [31:0] pc, input logic [5:0] st,
                              input logic [31:0] lo, output int n);
        int bad;
        bad = 0;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc_in(pc, st, 1'b0);
            if (mem_req_o && (mem_addr_o - lo) > 32'd3) bad++;
            if (inst_valid_o) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk({nm, " valid timeout"}, 32'd0, 32'd1);
        chk({nm, " out-of-range requests"}, bad, 0);
    endtask

    task automatic park(input logic [31:0] pc);
        cyc_in(pc, 6'd0, 1'b1);
        cyc_in(pc, 6'd0, 1'b1);
    endtask

    out_t IDLE_O;
    out_t WAIT_O;
    vec_t tv[12];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int n;
        int g0;
        mem[32'h100] = 8'h13; mem[32'h101] = 8'h05; mem[32'h102] = 8'h50; mem[32'h103] = 8'h00;
        mem[32'h200] = 8'h93; mem[32'h201] = 8'h00; mem[32'h202] = 8'h10; mem[32'h203] = 8'h00;
        mem[32'h300] = 8'h78; mem[32'h301] = 8'h56; mem[32'h302] = 8'h34; mem[32'h303] = 8'h12;
        mem[32'h400] = 8'hAA; mem[32'h401] = 8'hBB; mem[32'h402] = 8'hCC; mem[32'h403] = 8'hDD;
        IDLE_O = mk(1'b0, 32'd0, 1'b0, 1'b0, NOP, 32'd0);
        WAIT_O = mk(1'b0, 32'd0, 1'b1, 1'b0, NOP, 32'd0);
        tv[0]  = '{1'b0, IDLE_O};
        tv[1]  = '{1'b0, mk(1'b1, 32'h100, 1'b1, 1'b0, NOP, 32'd0)};
        tv[2]  = '{1'b0, WAIT_O};
        tv[3]  = '{1'b0, mk(1'b1, 32'h101, 1'b1, 1'b0, NOP, 32'd0)};
        tv[4]  = '{1'b0, WAIT_O};
        tv[5]  = '{1'b0, mk(1'b1, 32'h102, 1'b1, 1'b0, NOP, 32'd0)};
        tv[6]  = '{1'b0, WAIT_O};
        tv[7]  = '{1'b0, mk(1'b1, 32'h103, 1'b1, 1'b0, NOP, 32'd0)};
        tv[8]  = '{1'b0, WAIT_O};
        tv[9]  = '{1'b0, mk(1'b0, 32'd0, 1'b0, 1'b1, 32'h0050_0513, 32'h100)};
        tv[10] = '{1'b1, IDLE_O};
        tv[11] = '{1'b1, IDLE_O};

        // Reset values; flush holds the engine in IDLE after release.
        rst = 1'b0; pc_i = 32'h100; stall_i = 6'd0; flush_i = 1'b1;
        #2;
        chk_o("reset outputs", IDLE_O);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        park(32'h100);

        // 1: clean zero-wait fetch, cycle by cycle.
        for (int i = 0; i < 12; i++) begin
            cyc_in(32'h100, 6'd0, tv[i].flush);
            chk_o($sformatf("t1 cycle %0d", i), tv[i].exp);
        end

        // 2: grant withheld 5 cycles on byte 2.
        hold_addr = 32'h302; hold_n = 5;
        g0 = gnt_cnt;
        for (int i = 0; i < 5; i++) cyc_in(32'h300, 6'd0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            cyc_in(32'h300, 6'd0, 1'b0);
            chk($sformatf("t2 req/addr hold %0d", i), {mem_req_o, mem_addr_o[30:0]}, {1'b1, 31'h302});
        end
        wait_valid("t2", 32'h300, 6'd0, 32'h300, n);
        chk("t2 cycles after grant", n, 4);
        chk("t2 inst", inst_o, 32'h1234_5678);
        chk("t2 grants", gnt_cnt - g0, 4);
        park(32'h300);

        // 3: flush in WAIT of byte 1, byte returns 2 cycles later into DRAIN.
        slow_addr = 32'h401; slow_lat = 3;
        for (int i = 0; i < 4; i++) cyc_in(32'h400, 6'd0, 1'b0);
        cyc_in(32'h200, 6'd0, 1'b1);
        chk("t3 flush cycle in WAIT", {mem_req_o, stallreq_o}, 2'b01);
        cyc_in(32'h200, 6'd0, 1'b0);
        chk("t3 drain 1", {mem_req_o, stallreq_o, inst_valid_o}, 3'b010);
        cyc_in(32'h200, 6'd0, 1'b0);
        chk("t3 drain 2", {mem_req_o, stallreq_o, inst_valid_o}, 3'b010);
        cyc_in(32'h200, 6'd0, 1'b0);
        chk_o("t3 idle after drain", IDLE_O);
        cyc_in(32'h200, 6'd0, 1'b0);
        chk_o("t3 refetch addr", mk(1'b1, 32'h200, 1'b1, 1'b0, NOP, 32'd0));
        wait_valid("t3", 32'h200, 6'd0, 32'h200, n);
        chk("t3 inst", inst_o, 32'h0010_0093);
        chk("t3 inst_pc", inst_pc_o, 32'h200);
        park(32'h200);

        // 4: DONE held by IF/ID stall for 4 cycles, then a new fetch from updated pc.
        wait_valid("t4", 32'h100, 6'b000010, 32'h100, n);
        chk_o("t4 stall 0", mk(1'b0, 32'd0, 1'b1, 1'b1, 32'h0050_0513, 32'h100));
        for (int i = 1; i < 4; i++) begin
            cyc_in(32'h100, 6'b000010, 1'b0);
            chk_o($sformatf("t4 stall %0d", i), mk(1'b0, 32'd0, 1'b1, 1'b1, 32'h0050_0513, 32'h100));
        end
        cyc_in(32'h300, 6'd0, 1'b0);
        chk_o("t4 release", mk(1'b0, 32'd0, 1'b0, 1'b1, 32'h0050_0513, 32'h100));
        cyc_in(32'h300, 6'd0, 1'b0);
        chk_o("t4 idle", IDLE_O);
        cyc_in(32'h300, 6'd0, 1'b0);
        chk_o("t4 new req", mk(1'b1, 32'h300, 1'b1, 1'b0, NOP, 32'd0));
        wait_valid("t4b", 32'h300, 6'd0, 32'h300, n);
        chk("t4 second inst", inst_o, 32'h1234_5678);
        park(32'h300);

        // 5: no read data ever returns; err after 8 WAIT cycles.
        no_resp = 1'b1;
        for (int c = 0; c < 12; c++) begin
            cyc_in(32'h500, 6'd0, c >= 10);
            chk($sformatf("t5 err/vld cycle %0d", c), {err_o, inst_valid_o}, {c == 10, 1'b0});
        end
        chk("t5 back in idle", {stallreq_o, mem_req_o}, 2'b00);

        // 6: asynchronous reset mid-WAIT, then a stray byte in IDLE.
        cyc_in(32'h100, 6'd0, 1'b0);
        cyc_in(32'h100, 6'd0, 1'b0);
        cyc_in(32'h100, 6'd0, 1'b0);
        chk("t6 in WAIT", {mem_req_o, stallreq_o}, 2'b01);
        #1 rst = 1'b0;
        #1 chk_o("t6 async reset", IDLE_O);
        @(negedge clk);
        flush_i = 1'b1;
        rst = 1'b1;
        no_resp = 1'b0;
        #1 inject = 1'b1;
        g0 = gnt_cnt;
        cyc_in(32'h100, 6'd0, 1'b1);
        inject = 1'b0;
        chk_o("t6 stray rvalid", IDLE_O);
        cyc_in(32'h100, 6'd0, 1'b1);
        chk_o("t6 still idle", IDLE_O);
        wait_valid("t6", 32'h100, 6'd0, 32'h100, n);
        chk("t6 latency", n, 10);
        chk("t6 inst", inst_o, 32'h0050_0513);
        chk("t6 grants", gnt_cnt - g0, 4);
        park(32'h100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
